// File: rtl/key_disp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_disp_pkg : key codes and 7-segment patterns for key_entry_display    |
// | Revision     : 1.0                                                       |
// +-------------------------------------------------------------------------+
package key_disp_pkg;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_HASH  = 4'hB;
    localparam logic [3:0] KEY_LAST_DIGIT = 4'd9;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry [n] is the glyph for digit n.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage : key_disp_pkg
`default_nettype wire

// File: rtl/sseg_decode.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sseg_decode : BCD nibble to active-low 7-segment cathodes (dp off)       |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
module sseg_decode
    import key_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (nibble <= KEY_LAST_DIGIT) begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule : sseg_decode
`default_nettype wire

// File: rtl/key_entry_display.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_entry_display : keypad 4-digit BCD entry with multiplexed display    |
// | Option macro LEADING_ZERO_BLANK_EN blanks slots beyond the digit count.  |
// | Revision          : 1.0                                                  |
// +-------------------------------------------------------------------------+
module key_entry_display
    import key_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  KEY_VAL,
    input  logic        KEY_PRESS,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [15:0] VALUE,
    output logic        ENTER,
    output logic [2:0]  DIGIT_CNT
);

    localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic             press_q,     press_d;
    logic [15:0]      buffer_q,    buffer_d;
    logic [15:0]      value_q,     value_d;
    logic             enter_q,     enter_d;
    logic [2:0]       digit_cnt_q, digit_cnt_d;
    logic [CNT_W-1:0] refresh_q,   refresh_d;
    logic [1:0]       sel_q,       sel_d;
    logic [3:0]       an_q,        an_d;
    logic [7:0]       seg_q,       seg_d;

    logic             accept;
    logic             wrap;
    logic             blank;
    logic [3:0]       scan_nibble;
    logic [7:0]       scan_seg;

    // Rising edge of the keypad level is the only thing treated as a press.
    always_comb begin
        press_d     = KEY_PRESS;
        accept      = KEY_PRESS && !press_q;
        buffer_d    = buffer_q;
        value_d     = value_q;
        enter_d     = 1'b0;
        digit_cnt_d = digit_cnt_q;

        if (accept) begin
            if (KEY_VAL <= KEY_LAST_DIGIT) begin
                buffer_d    = {buffer_q[11:0], KEY_VAL};
                digit_cnt_d = (digit_cnt_q < 3'd4) ? digit_cnt_q + 3'd1 : 3'd4;
            end else if (KEY_VAL == KEY_STAR) begin
                buffer_d    = '0;
                digit_cnt_d = '0;
            end else if (KEY_VAL == KEY_HASH) begin
                value_d     = buffer_q;
                enter_d     = 1'b1;
                buffer_d    = '0;
                digit_cnt_d = '0;
            end
        end
    end

    always_comb begin
        wrap      = (refresh_q == CNT_MAX);
        refresh_d = wrap ? '0 : refresh_q + 1'b1;
        sel_d     = wrap ? sel_q + 2'd1 : sel_q;
    end

    // Drive the scan from next-state values so an/seg line up with sel_q/buffer_q.
    assign scan_nibble = buffer_d[{sel_d, 2'b00} +: 4];

    sseg_decode u_sseg_decode (
        .nibble (scan_nibble),
        .seg    (scan_seg)
    );

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        blank = (sel_d != 2'd0) && ({1'b0, sel_d} >= digit_cnt_d);
`else
        blank = 1'b0;
`endif
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (!blank) begin
            an_d[sel_d] = 1'b0;
            seg_d       = scan_seg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            press_q     <= 1'b1;
            buffer_q    <= '0;
            value_q     <= '0;
            enter_q     <= 1'b0;
            digit_cnt_q <= '0;
            refresh_q   <= '0;
            sel_q       <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            press_q     <= press_d;
            buffer_q    <= buffer_d;
            value_q     <= value_d;
            enter_q     <= enter_d;
            digit_cnt_q <= digit_cnt_d;
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign VALUE     = value_q;
    assign ENTER     = enter_q;
    assign DIGIT_CNT = digit_cnt_q;

endmodule : key_entry_display
`default_nettype wire

// File: tb/tb_key_entry_display.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_key_entry_display : self-checking bench for key_entry_display         |
// | Revision             : 1.0                                               |
// +-------------------------------------------------------------------------+
module tb_key_entry_display;

    localparam int DIV = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  KEY_VAL;
    logic        KEY_PRESS;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] VALUE;
    logic        ENTER;
    logic [2:0]  DIGIT_CNT;

    always #5 CLK = ~CLK;

    key_entry_display #(.REFRESH_DIV(DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY_VAL   (KEY_VAL),
        .KEY_PRESS (KEY_PRESS),
        .an        (an),
        .seg       (seg),
        .VALUE     (VALUE),
        .ENTER     (ENTER),
        .DIGIT_CNT (DIGIT_CNT)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the entry buffer as a plain integer, scan slot from elapsed cycles.
    int m_buf, m_val, m_cnt, m_enter, m_prev, m_n, m_rst;

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: pat = 8'hC0; 1: pat = 8'hF9; 2: pat = 8'hA4; 3: pat = 8'hB0;
            4: pat = 8'h99; 5: pat = 8'h92; 6: pat = 8'h82; 7: pat = 8'hF8;
            8: pat = 8'h80; 9: pat = 8'h90;
            default: pat = 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int v;
        if (RST) begin
            m_buf = 0; m_val = 0; m_cnt = 0; m_enter = 0; m_prev = 1; m_n = 0; m_rst = 1;
        end else begin
            m_rst   = 0;
            m_n     = m_n + 1;
            m_enter = 0;
            v = int'(KEY_VAL);
            if (KEY_PRESS && m_prev == 0) begin
                if (v <= 9) begin
                    m_buf = (m_buf * 16 + v) % 65536;
                    m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
                end else if (v == 10) begin
                    m_buf = 0; m_cnt = 0;
                end else if (v == 11) begin
                    m_val = m_buf; m_enter = 1; m_buf = 0; m_cnt = 0;
                end
            end
            m_prev = int'(KEY_PRESS);
        end
    endtask

    task automatic tick();
        int slot;
        bit lit;
        logic [3:0] an_e;
        logic [7:0] seg_e;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        an_e  = 4'hF;
        seg_e = 8'hFF;
        if (!m_rst) begin
            slot = (m_n / DIV) % 4;
`ifdef LEADING_ZERO_BLANK_EN
            lit = (slot == 0) || (slot < m_cnt);
`else
            lit = 1'b1;
`endif
            if (lit) begin
                an_e  = 4'hF & ~(4'(1) << slot);
                seg_e = pat((m_buf >> (4 * slot)) & 15);
            end
        end
        check("VALUE", 32'(VALUE), 32'(m_val));
        check("ENTER", 32'(ENTER), 32'(m_enter));
        check("DIGIT_CNT", 32'(DIGIT_CNT), 32'(m_cnt));
        check("an", 32'(an), 32'(an_e));
        check("seg", 32'(seg), 32'(seg_e));
    endtask

    task automatic press(input logic [3:0] v);
        KEY_VAL = v; KEY_PRESS = 1'b1;
        tick(); tick();
        KEY_PRESS = 1'b0;
        tick(); tick();
    endtask

    // Reconstruct the displayed number by watching one full scan cycle.
    task automatic read_display(output logic [15:0] b);
        b = '0;
        for (int c = 0; c < 4 * DIV; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (an == (4'hF & ~(4'(1) << k))) begin
                    for (int d = 0; d < 10; d++) begin
                        if (seg == pat(d)) b[4*k +: 4] = 4'(d);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [15:0] buf_e;
        logic [2:0]  cnt_e;
        logic [15:0] val_e;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [15:0] shown;
        int n_enter, lit_other;

        vt[0]  = '{4'h1, 16'h0001, 3'd1, 16'h0000};
        vt[1]  = '{4'h2, 16'h0012, 3'd2, 16'h0000};
        vt[2]  = '{4'h3, 16'h0123, 3'd3, 16'h0000};
        vt[3]  = '{4'h4, 16'h1234, 3'd4, 16'h0000};
        vt[4]  = '{4'h5, 16'h2345, 3'd4, 16'h0000};
        vt[5]  = '{4'hB, 16'h0000, 3'd0, 16'h2345};
        vt[6]  = '{4'h7, 16'h0007, 3'd1, 16'h2345};
        vt[7]  = '{4'h8, 16'h0078, 3'd2, 16'h2345};
        vt[8]  = '{4'hB, 16'h0000, 3'd0, 16'h0078};
        vt[9]  = '{4'h9, 16'h0009, 3'd1, 16'h0078};
        vt[10] = '{4'hA, 16'h0000, 3'd0, 16'h0078};
        vt[11] = '{4'hC, 16'h0000, 3'd0, 16'h0078};
        vt[12] = '{4'hB, 16'h0000, 3'd0, 16'h0000};

        KEY_VAL = 4'h0; KEY_PRESS = 1'b0;
        do_reset();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        tick();
        check("first_lit_an", 32'(an), 32'hE);

        // Digits are shown without blanking only in the default build.
        for (int i = 0; i < 13; i++) begin
            press(vt[i].key);
            check($sformatf("vec%0d_cnt", i), 32'(DIGIT_CNT), 32'(vt[i].cnt_e));
            check($sformatf("vec%0d_val", i), 32'(VALUE), 32'(vt[i].val_e));
`ifndef LEADING_ZERO_BLANK_EN
            read_display(shown);
            check($sformatf("vec%0d_buf", i), 32'(shown), 32'(vt[i].buf_e));
`endif
        end

        // '#' produces exactly one ENTER cycle even while held.
        press(4'h7); press(4'h8);
        KEY_VAL = 4'hB; KEY_PRESS = 1'b1;
        n_enter = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ENTER) n_enter++;
        end
        KEY_PRESS = 1'b0; tick();
        check("enter_pulses", 32'(n_enter), 32'd1);
        check("enter_value", 32'(VALUE), 32'h0078);
        check("enter_cnt", 32'(DIGIT_CNT), 32'd0);

        // Long hold accepts one digit; '*' clears it and keeps VALUE.
        KEY_VAL = 4'h9; KEY_PRESS = 1'b1;
        for (int c = 0; c < 50; c++) tick();
        KEY_PRESS = 1'b0; tick();
        check("hold_cnt", 32'(DIGIT_CNT), 32'd1);
        press(4'hA);
        check("star_cnt", 32'(DIGIT_CNT), 32'd0);
        check("star_val", 32'(VALUE), 32'h0078);

        // Reset with a key held: nothing is accepted until a fresh press.
        press(4'h3);
        KEY_VAL = 4'h6; KEY_PRESS = 1'b1;
        tick();
        RST = 1'b1; tick(); tick(); tick(); RST = 1'b0;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_val", 32'(VALUE), 32'h0);
        check("midrst_cnt", 32'(DIGIT_CNT), 32'd0);
        check("midrst_enter", 32'(ENTER), 32'd0);
        tick();
        check("midrst_first_an", 32'(an), 32'hE);
        for (int c = 0; c < 5; c++) tick();
        check("midrst_held_cnt", 32'(DIGIT_CNT), 32'd0);
        KEY_PRESS = 1'b0; tick();
        press(4'h6);
        check("midrst_repress_cnt", 32'(DIGIT_CNT), 32'd1);

        // Single digit: other slots light only without blanking.
        do_reset();
        press(4'h5);
        lit_other = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (an != 4'hE && an != 4'hF) lit_other++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_other_slots", 32'(lit_other), 32'd0);
`else
        check("lzb_other_slots", 32'(lit_other > 0), 32'd1);
`endif

        // Random key activity with occasional resets.
        for (int c = 0; c < 600; c++) begin
            RST = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 3) == 0) begin
                KEY_PRESS = ~KEY_PRESS;
                if (KEY_PRESS) KEY_VAL = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(10, 15))
                                                                       : 4'($urandom_range(0, 9));
            end
            tick();
        end
        RST = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_entry_display
`default_nettype wire

// File: doc/key_entry_display.md
KEY_ENTRY_DISPLAY -- requirements
Module: key_entry_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, sets the CLK cycles each digit stays lit (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 CLK  in  1  sole clock, all logic rising-edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 KEY_VAL  in  4  key code from the keypad driver: 0-9 = digit, 4'hA = '*', 4'hB = '#', 4'hC-4'hF = ignored.
REQ-005 KEY_PRESS  in  1  keypad driver interrupt level; high while a key is held, KEY_VAL valid while high.
REQ-006 an  out  4  anode enables, active-low; an[0] = rightmost (least significant) digit.
REQ-007 seg  out  8  cathodes, active-low; seg[0]=a .. seg[6]=g, seg[7]=dp.
REQ-008 VALUE  out  16  last entered 4-digit BCD number; VALUE[3:0] = least significant digit.
REQ-009 ENTER  out  1  single-cycle pulse when VALUE is updated.
REQ-010 DIGIT_CNT  out  3  number of digits currently in the entry buffer (0-4).

Function
REQ-011 Press detect: one flop press_q holds the previous KEY_PRESS; a key is accepted on the clock edge where KEY_PRESS=1 and press_q=0; holding the key accepts nothing further.
REQ-012 Digit key: buffer <= {buffer[11:0], KEY_VAL}; DIGIT_CNT <= min(DIGIT_CNT+1, 4); a 5th digit discards the oldest digit and leaves DIGIT_CNT at 4.
REQ-013 '*': buffer <= 0, DIGIT_CNT <= 0; VALUE is unchanged.
REQ-014 '#': VALUE <= buffer, ENTER=1 for exactly the next cycle, buffer <= 0, DIGIT_CNT <= 0; '#' with DIGIT_CNT=0 still loads VALUE=0 and pulses ENTER.
REQ-015 Codes 4'hC-4'hF are accepted as presses, change no state, and produce no ENTER.
REQ-016 Latency: buffer, DIGIT_CNT and VALUE are visible one cycle after the first high sample of KEY_PRESS.
REQ-017 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap the digit select advances 0->1->2->3->0.
REQ-018 Digit select k: an has only bit k low; seg = decoded buffer nibble k; dp (seg[7]) is always 1.
REQ-019 Decoder: 0-9 use standard patterns; any non-BCD nibble shows all segments off (8'hFF).
REQ-020 an and seg are registered; no an transition glitches within a cycle.
REQ-021 A key press accepted on the same edge as a refresh wrap is handled normally; both take effect.

Reset
REQ-022 While RST=1 at a clock edge: buffer=0, VALUE=0, DIGIT_CNT=0, ENTER=0, press_q=1, refresh counter=0, digit select=0, an=4'b1111, seg=8'hFF.
REQ-023 Reset has priority over a simultaneous press.
REQ-024 press_q=1 after reset ensures a key still held through reset is not accepted until it is released and pressed again.
REQ-025 The first lit digit (an=4'b1110) appears the cycle after RST deasserts.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN.
REQ-027 Defined: a digit slot k >= DIGIT_CNT is blanked (an bit held high) in its scan slot. With DIGIT_CNT=0, slot 0 shows '0'.
REQ-028 Undefined: all four slots are always lit and show buffer nibbles, including leading zeros.

Structure
REQ-029 Package key_disp_pkg holds: key code constants (KEY_STAR=4'hA, KEY_HASH=4'hB), the 7-seg pattern table, and the blank pattern 8'hFF.
REQ-030 One combinational sub-module, sseg_decode, maps a 4-bit nibble to 8-bit active-low seg; everything else is in key_entry_display.

Verification (REFRESH_DIV=4 for sim)
REQ-031 Reset, then press 1,2,3,4 -> DIGIT_CNT=4 and scan shows 4 on an=1110, 3 on 1101, 2 on 1011, 1 on 0111; seg for '1' = 8'hF9.
REQ-032 Press 1,2,3,4,5 -> buffer 16'h2345, DIGIT_CNT=4.
REQ-033 Press 7,8 then '#' -> VALUE=16'h0078, ENTER high for exactly 1 cycle, DIGIT_CNT=0.
REQ-034 Press 9, hold KEY_PRESS high for 50 cycles -> exactly one digit is accepted; '*' -> buffer=0, VALUE keeps its previous value.
REQ-035 Assert RST mid-entry with the key held, then release RST -> all outputs match their reset values; the held key is not accepted until it is released and pressed again.
REQ-036 With LEADING_ZERO_BLANK_EN defined, press 5 -> only an=1110 ever goes low, showing '5' (8'h92); without the macro, slots 1-3 show '0' (8'hC0).
